controle_barramento: RTL and testbench

- Transfer sequencer that owns the control side of the 6-port shared 16-bit bus. The bus itself only routes data when told to.
- Accepts queued transfer requests (source port -> destination port) and drives the six 2-bit ctrl lanes. Bit 1 = port writes onto bus; bit 0 = port reads from bus.
- Guarantees exactly one writer at a time, and opens the reader only after the bus pipeline latency has elapsed.
- Sits beside the control unit, which issues transfer requests to it instead of driving ctrl lanes directly.

---
 rtl/controle_barramento.sv | 155 +++++++++++++++
 tb/tb_controle_barramento.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_barramento.sv
// controle_barramento: transfer sequencer for the 6-port shared 16-bit bus.
// Queues transfer requests (src -> dst) and drives the per-port {write, read}
// lane controls. Only one writer is active at a time. The reader lane opens
// only after the source has driven for BUS_LAT cycles.
module controle_barramento #(
  parameter int N_PORTS    = 6,
  parameter int BUS_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_src,
  input  logic [2:0] req_dst,
  output logic [1:0] ctrl_0,
  output logic [1:0] ctrl_1,
  output logic [1:0] ctrl_2,
  output logic [1:0] ctrl_3,
  output logic [1:0] ctrl_4,
  output logic [1:0] ctrl_5,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] err_src
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, READ} state_t;

  state_t          state, state_next;
  logic [2:0]      fifo_src [FIFO_DEPTH];
  logic [2:0]      fifo_dst [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [2:0]      src_r, dst_r;
  logic [3:0]      lat_cnt;
  logic            req_bad, accept, push, pop;
  logic [5:0][1:0] lane_next, lane_q;
  logic            done_next;

  // Handshake and validation are purely combinational from the occupancy count.
  assign req_ready = (count != CW'(FIFO_DEPTH));
  assign req_bad   = (req_src >= 3'(N_PORTS)) || (req_dst >= 3'(N_PORTS)) ||
                     (req_src == req_dst);
  assign accept    = req_valid && req_ready;
  assign push      = accept && !req_bad;
  assign pop       = ((state == IDLE) || (state == READ)) && (count != '0);
  assign busy      = (state != IDLE) || (count != '0);

  // Request storage: written on every accepted valid request.
  // NOTE: the storage array is not reset; emptiness is defined by the reset
  // pointers and count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src[wr_ptr] <= req_src;
      fifo_dst[wr_ptr] <= req_dst;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state: READ chains straight into DRIVE when work is queued.
  // NOTE: state_next gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = DRIVE;
      DRIVE:   if (lat_cnt == '0) state_next = READ;
      READ:    state_next = pop ? DRIVE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Active transfer registers: loaded on pop, latency counted down in DRIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_r   <= '0;
      dst_r   <= '0;
      lat_cnt <= '0;
    end else if (pop) begin
      src_r   <= fifo_src[rd_ptr];
      dst_r   <= fifo_dst[rd_ptr];
      lat_cnt <= 4'(BUS_LAT - 1);
    end else if ((state == DRIVE) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Output decode: source writes in DRIVE and READ, destination reads in READ.
  always_comb begin
    lane_next = '0;
    done_next = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if ((state != IDLE) && (src_r == 3'(i))) lane_next[i][1] = 1'b1;
      if ((state == READ) && (dst_r == 3'(i))) lane_next[i][0] = 1'b1;
    end
    if (state == READ) done_next = 1'b1;
  end

  // Registered lanes and done, so done lines up with the read lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      done   <= 1'b0;
    end else begin
      lane_q <= lane_next;
      done   <= done_next;
    end
  end

  // Rejected-request reporting: pulse next cycle and remember the source id.
  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_src <= '0;
    end else begin
      err <= accept && req_bad;
      if (accept && req_bad) err_src <= req_src;
    end
  end

  assign ctrl_0 = lane_q[0];
  assign ctrl_1 = lane_q[1];
  assign ctrl_2 = lane_q[2];
  assign ctrl_3 = lane_q[3];
  assign ctrl_4 = lane_q[4];
  assign ctrl_5 = lane_q[5];

endmodule

// File: tb/tb_controle_barramento.sv
// Testbench for controle_barramento: randomized and directed requests,
// scoreboard queues filled at issue time, negedge monitor pops and compares.
module tb_controle_barramento;

  localparam int LAT = 2;

  typedef struct packed {
    logic [2:0] src;
    logic [2:0] dst;
  } xfer_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_src = '0, req_dst = '0;
  logic       req_ready, busy, done, err;
  logic [2:0] err_src;
  logic [1:0] ctrl_0, ctrl_1, ctrl_2, ctrl_3, ctrl_4, ctrl_5;

  // Second build with BUS_LAT = 1.
  logic       l1_valid = 1'b0;
  logic [2:0] l1_src = '0, l1_dst = '0;
  logic       l1_ready, l1_busy, l1_done, l1_err;
  logic [2:0] l1_err_src;
  logic [1:0] l1_c0, l1_c1, l1_c2, l1_c3, l1_c4, l1_c5;

  int n_checks = 0;
  int n_fail   = 0;

  xfer_t      exp_q[$];
  logic [2:0] err_q[$];

  int done_cnt = 0, idle_cnt = 0, writer_cycles = 0;
  int acc_cnt = 0, stall_at = -1;

  always #5 clk = ~clk;

  controle_barramento #(.N_PORTS(6), .BUS_LAT(LAT), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst),
    .ctrl_0(ctrl_0), .ctrl_1(ctrl_1), .ctrl_2(ctrl_2),
    .ctrl_3(ctrl_3), .ctrl_4(ctrl_4), .ctrl_5(ctrl_5),
    .busy(busy), .done(done), .err(err), .err_src(err_src)
  );

  controle_barramento #(.N_PORTS(6), .BUS_LAT(1), .FIFO_DEPTH(4)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(l1_valid), .req_ready(l1_ready),
    .req_src(l1_src), .req_dst(l1_dst),
    .ctrl_0(l1_c0), .ctrl_1(l1_c1), .ctrl_2(l1_c2),
    .ctrl_3(l1_c3), .ctrl_4(l1_c4), .ctrl_5(l1_c5),
    .busy(l1_busy), .done(l1_done), .err(l1_err), .err_src(l1_err_src)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word each port drives onto the bus; port 2 drives 0xA5C3.
  function automatic logic [15:0] word(input int i);
    return 16'hA5C3 ^ (16'(i) * 16'h1111) ^ 16'h2222;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] hist [16];
  int          run = 0, prev_wid = -1;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    logic [1:0] l [6];
    int nw, nr, wid;
    logic ok;
    xfer_t e;
    l = '{ctrl_0, ctrl_1, ctrl_2, ctrl_3, ctrl_4, ctrl_5};
    if (rst) begin
      run = 0;
      prev_wid = -1;
      prev_done = 1'b0;
      for (int i = 0; i < 16; i++) hist[i] = '0;
    end else begin
      nw = 0; nr = 0; wid = -1; ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (l[i] == 2'b11) ok = 1'b0;
        if (l[i][1]) begin nw++; wid = i; end
        if (l[i][0]) nr++;
      end
      if (nw > 1 || nr > 1 || (nr == 1 && nw == 0)) ok = 1'b0;
      check("lane_invariant", ok, 1);

      if (wid < 0) begin
        run = 0;
        idle_cnt++;
      end else begin
        writer_cycles++;
        run = (wid == prev_wid && !prev_done) ? run + 1 : 1;
      end

      if (done) begin
        done_cnt++;
        check("done_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_writer_lane", l[e.src], 2'b10);
          check("done_reader_lane", l[e.dst], 2'b01);
          check("write_run_length", run, LAT + 1);
          check("bus_data", hist[LAT-1], word(int'(e.src)));
        end
      end else begin
        check("read_without_done", nr, 0);
      end

      if (err) begin
        check("err_has_expected", err_q.size() != 0, 1);
        if (err_q.size() != 0) check("err_src", err_src, err_q.pop_front());
      end

      for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = (wid >= 0) ? word(wid) : 16'h0000;
      prev_wid = wid;
      prev_done = done;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait (bounded) for ready, record the expectation.
  task automatic send(input logic [2:0] s, input logic [2:0] d);
    int budget = 0;
    req_valid = 1'b1;
    req_src = s;
    req_dst = d;
    if (!req_ready && stall_at < 0) stall_at = acc_cnt;
    while (!req_ready && budget < 200) begin
      tick();
      budget++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", req_ready, 1);
    end else begin
      if (s > 5 || d > 5 || s == d) err_q.push_back(s);
      else exp_q.push_back('{src: s, dst: d});
      acc_cnt++;
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0 || busy) && budget < 500) begin
      tick();
      budget++;
    end
    tick();
    tick();
    check("drain_complete", exp_q.size() + err_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc, wc, ic, budget;
    logic [5:0] s4, s0, sd;

    repeat (3) tick();
    check("reset_lanes", {ctrl_5, ctrl_4, ctrl_3, ctrl_2, ctrl_1, ctrl_0}, 0);
    check("reset_flags", {busy, done, err}, 0);
    check("reset_err_src", err_src, 0);
    check("reset_ready", req_ready, 1);
    rst = 1'b0;
    tick();

    // Single transfer 2 -> 4.
    dc = done_cnt; wc = writer_cycles;
    send(3'd2, 3'd4);
    drain();
    check("single_done_count", done_cnt - dc, 1);
    check("single_writer_cycles", writer_cycles - wc, 3);

    // Back-to-back transfers without idle gaps.
    dc = done_cnt; wc = writer_cycles;
    send(3'd0, 3'd1);
    send(3'd1, 3'd5);
    send(3'd5, 3'd0);
    budget = 0;
    while (writer_cycles == wc && budget < 50) begin tick(); budget++; end
    ic = idle_cnt;
    budget = 0;
    while (done_cnt - dc < 3 && budget < 100) begin tick(); budget++; end
    check("b2b_idle_gap", idle_cnt - ic, 0);
    drain();
    check("b2b_done_count", done_cnt - dc, 3);
    check("b2b_writer_cycles", writer_cycles - wc, 9);

    // Overflow: one transfer then six more held back-to-back. The first is
    // popped immediately and the next one at the first READ, so the queue
    // reaches four entries after six accepted requests.
    dc = done_cnt;
    acc_cnt = 0;
    stall_at = -1;
    send(3'd0, 3'd3);
    send(3'd1, 3'd2);
    send(3'd2, 3'd3);
    send(3'd3, 3'd4);
    send(3'd4, 3'd5);
    send(3'd5, 3'd1);
    send(3'd3, 3'd0);
    check("overflow_stall_point", stall_at, 6);
    drain();
    check("overflow_done_count", done_cnt - dc, 7);

    // Invalid requests: consumed, error reported, no lane activity.
    dc = done_cnt; wc = writer_cycles;
    send(3'd3, 3'd3);
    send(3'd6, 3'd1);
    send(3'd0, 3'd7);
    drain();
    check("invalid_no_done", done_cnt - dc, 0);
    check("invalid_no_lanes", writer_cycles - wc, 0);
    check("invalid_not_busy", busy, 0);

    // Randomized mix of valid and invalid requests with random gaps.
    for (int k = 0; k < 30; k++) begin
      send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();

    // Reset during DRIVE of 1 -> 2 with two more queued.
    dc = done_cnt;
    send(3'd1, 3'd2);
    send(3'd3, 3'd4);
    send(3'd5, 3'd0);
    budget = 0;
    while (ctrl_1 != 2'b10 && budget < 20) begin tick(); budget++; end
    check("midreset_drive_seen", ctrl_1, 2'b10);
    rst = 1'b1;
    exp_q.delete();
    err_q.delete();
    tick();
    rst = 1'b0;
    check("midreset_lanes", {ctrl_5, ctrl_4, ctrl_3, ctrl_2, ctrl_1, ctrl_0}, 0);
    check("midreset_flags", {busy, done, err}, 0);
    check("midreset_err_src", err_src, 0);
    check("midreset_ready", req_ready, 1);
    wc = writer_cycles;
    repeat (8) tick();
    check("midreset_no_done", done_cnt - dc, 0);
    check("midreset_no_lanes", writer_cycles - wc, 0);
    send(3'd0, 3'd5);
    drain();
    check("postreset_done", done_cnt - dc, 1);

    // BUS_LAT = 1 build: transfer 4 -> 0.
    check("lat1_idle_ready", l1_ready, 1);
    l1_valid = 1'b1;
    l1_src = 3'd4;
    l1_dst = 3'd0;
    tick();
    l1_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s4[k] = (l1_c4 == 2'b10);
      s0[k] = (l1_c0 == 2'b01);
      sd[k] = l1_done;
      tick();
    end
    check("lat1_src_lane", s4, 6'b001100);
    check("lat1_dst_lane", s0, 6'b001000);
    check("lat1_done", sd, 6'b001000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
